// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_unit
//  Description : Multi-cycle (FETCH/EXEC) control unit. Fetches 16-bit
//                instructions, decodes them for one EXEC cycle into the
//                datapath control word, and sequences the program counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    input  logic            z_in,
    input  logic            n_in,
    output logic [2:0]      DA,
    output logic [2:0]      AA,
    output logic [2:0]      BA,
    output logic            MB,
    output logic [3:0]      FS,
    output logic            MD,
    output logic            RW,
    output logic            mem_we,
    output logic [15:0]     const_out,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [6:0] c_OP_LD  = 7'b0010000;
    localparam logic [6:0] c_OP_ST  = 7'b0100000;
    localparam logic [6:0] c_OP_BRZ = 7'b1100000;
    localparam logic [6:0] c_OP_BRN = 7'b1100001;
    localparam logic [6:0] c_OP_HLT = 7'b0111111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            illegal_q, illegal_d;

    // Instruction fields
    logic [6:0]      w_op;
    logic [2:0]      w_dr, w_sa, w_sb;
    logic [5:0]      w_off6;
    logic [PC_W-1:0] w_off;
    logic [PC_W-1:0] w_pc_inc;

    assign w_op     = ir_q[15:9];
    assign w_dr     = ir_q[8:6];
    assign w_sa     = ir_q[5:3];
    assign w_sb     = ir_q[2:0];
    assign w_off6   = {w_dr, w_sb};
    assign w_off    = {{(PC_W-6){w_off6[5]}}, w_off6};
    assign w_pc_inc = pc_q + PC_W'(1);

    assign imem_addr = pc_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

    // State, PC, IR and sticky illegal flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic and control-word decode; outputs are zero outside EXEC
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        imem_req  = 1'b0;
        DA        = 3'd0;
        AA        = 3'd0;
        BA        = 3'd0;
        MB        = 1'b0;
        FS        = 4'b0000;
        MD        = 1'b0;
        RW        = 1'b0;
        mem_we    = 1'b0;
        const_out = 16'd0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                const_out = {13'd0, w_sb};
                pc_d      = w_pc_inc;
                state_d   = S_FETCH;
                // ALU reg (000) and ALU imm (100) share decode, op[6] selects the constant
                if (w_op[5:4] == 2'b00 && (w_op[6:4] == 3'b000 || w_op[6:4] == 3'b100)) begin
                    DA = w_dr;
                    AA = w_sa;
                    BA = w_sb;
                    MB = w_op[6];
                    FS = w_op[3:0];
                    RW = 1'b1;
                end else begin
                    case (w_op)
                        c_OP_LD: begin
                            DA = w_dr;
                            AA = w_sa;
                            MD = 1'b1;
                            RW = 1'b1;
                        end
                        c_OP_ST: begin
                            AA     = w_sa;
                            BA     = w_sb;
                            mem_we = 1'b1;
                        end
                        c_OP_BRZ: begin
                            AA = w_sa;
                            if (z_in) pc_d = w_pc_inc + w_off;
                        end
                        c_OP_BRN: begin
                            AA = w_sa;
                            if (n_in) pc_d = w_pc_inc + w_off;
                        end
                        c_OP_HLT: begin
                            pc_d    = pc_q;
                            state_d = S_HALT;
                        end
                        default: begin
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_control_unit
//  Description : Directed self-checking bench for cpu_control_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        z_in;
    logic        n_in;
    logic [2:0]  DA, AA, BA;
    logic        MB, MD, RW, mem_we;
    logic [3:0]  FS;
    logic [15:0] const_out;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    cpu_control_unit #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .z_in       (z_in),
        .n_in       (n_in),
        .DA         (DA),
        .AA         (AA),
        .BA         (BA),
        .MB         (MB),
        .FS         (FS),
        .MD         (MD),
        .RW         (RW),
        .mem_we     (mem_we),
        .const_out  (const_out),
        .halted     (halted),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction after 'waits' idle cycles; returns at the negedge inside EXEC
    task automatic fetch(input logic [15:0] instr, input int waits);
        imem_valid = 1'b0;
        repeat (waits) begin
            @(posedge clk);
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_data  = instr;
        @(posedge clk);
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 16'hDEAD;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 16'h0000); end
        checks++; if ({RW, mem_we, MD, MB} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected %b", {RW, mem_we, MD, MB}, 4'b0000); end
        checks++; if ({halted, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected %b", {halted, illegal}, 2'b00); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected %b", imem_req, 1'b1); end
    endtask

    task automatic test_alu_reg();
        // ADD r2 <- r2 + r1 : op 0000010, dr=2, sa=2, sb=1
        fetch(16'h0491, 0);
        checks++; if ({DA, AA, BA} !== {3'd2, 3'd2, 3'd1}) begin errors++; $display("FAIL add_regs: got %h expected %h", {DA, AA, BA}, {3'd2, 3'd2, 3'd1}); end
        checks++; if (FS !== 4'b0010) begin errors++; $display("FAIL add_fs: got %b expected %b", FS, 4'b0010); end
        checks++; if ({MB, MD, RW, mem_we, imem_req} !== 5'b00100) begin errors++; $display("FAIL add_strobes: got %b expected %b", {MB, MD, RW, mem_we, imem_req}, 5'b00100); end
        step();
        checks++; if (imem_addr !== 16'h0001) begin errors++; $display("FAIL add_pc: got %h expected %h", imem_addr, 16'h0001); end
        checks++; if ({RW, imem_req} !== 2'b01) begin errors++; $display("FAIL add_after: got %b expected %b", {RW, imem_req}, 2'b01); end
    endtask

    task automatic test_alu_imm();
        // ADI r4 <- r0 + 5
        fetch(16'h8505, 0);
        checks++; if ({MB, RW} !== 2'b11) begin errors++; $display("FAIL adi_mb_rw: got %b expected %b", {MB, RW}, 2'b11); end
        checks++; if (const_out !== 16'h0005) begin errors++; $display("FAIL adi_const: got %h expected %h", const_out, 16'h0005); end
        checks++; if ({DA, FS} !== {3'd4, 4'b0010}) begin errors++; $display("FAIL adi_da_fs: got %h expected %h", {DA, FS}, {3'd4, 4'b0010}); end
        step();
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL adi_pc: got %h expected %h", imem_addr, 16'h0002); end
    endtask

    task automatic test_ld_st();
        fetch(16'h2048, 0);
        checks++; if ({MD, RW, mem_we} !== 3'b110) begin errors++; $display("FAIL ld_strobes: got %b expected %b", {MD, RW, mem_we}, 3'b110); end
        checks++; if ({DA, AA} !== {3'd1, 3'd1}) begin errors++; $display("FAIL ld_regs: got %h expected %h", {DA, AA}, {3'd1, 3'd1}); end
        step();
        fetch(16'h401A, 0);
        checks++; if ({mem_we, RW, MD} !== 3'b100) begin errors++; $display("FAIL st_strobes: got %b expected %b", {mem_we, RW, MD}, 3'b100); end
        checks++; if ({AA, BA} !== {3'd3, 3'd2}) begin errors++; $display("FAIL st_regs: got %h expected %h", {AA, BA}, {3'd3, 3'd2}); end
        step();
        checks++; if ({mem_we, imem_addr} !== {1'b0, 16'h0004}) begin errors++; $display("FAIL st_after: got %h expected %h", {mem_we, imem_addr}, {1'b0, 16'h0004}); end
    endtask

    task automatic test_wait_illegal();
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({imem_req, imem_addr, RW, mem_we} !== {1'b1, 16'h0004, 2'b00}) begin errors++; $display("FAIL wait_%0d: got %h expected %h", i, {imem_req, imem_addr, RW, mem_we}, {1'b1, 16'h0004, 2'b00}); end
        end
        fetch(16'h7000, 0);
        checks++; if ({RW, mem_we, MD} !== 3'b000) begin errors++; $display("FAIL ill_strobes: got %b expected %b", {RW, mem_we, MD}, 3'b000); end
        step();
        checks++; if ({illegal, imem_addr} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL ill_flag: got %h expected %h", {illegal, imem_addr}, {1'b1, 16'h0005}); end
    endtask

    task automatic test_branch();
        // BRZ offset -2 at pc=5, taken
        fetch(16'hC1C6, 0);
        checks++; if ({RW, mem_we, FS, AA} !== {2'b00, 4'b0000, 3'd0}) begin errors++; $display("FAIL brz_ctrl: got %h expected %h", {RW, mem_we, FS, AA}, {2'b00, 4'b0000, 3'd0}); end
        z_in = 1'b1; n_in = 1'b0;
        step();
        z_in = 1'b0;
        checks++; if (imem_addr !== 16'h0004) begin errors++; $display("FAIL brz_taken: got %h expected %h", imem_addr, 16'h0004); end
        // not taken at pc=4 -> 5, n_in high must not affect BRZ
        fetch(16'hC1C6, 0);
        z_in = 1'b0; n_in = 1'b1;
        step();
        n_in = 1'b0;
        checks++; if (imem_addr !== 16'h0005) begin errors++; $display("FAIL brz_nz_n: got %h expected %h", imem_addr, 16'h0005); end
        fetch(16'hC1C6, 0);
        step();
        checks++; if (imem_addr !== 16'h0006) begin errors++; $display("FAIL brz_not_taken: got %h expected %h", imem_addr, 16'h0006); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %b expected %b", illegal, 1'b1); end
        // BRZ offset -8 at pc=6 -> 0xFFFF
        fetch(16'hC1C0, 0);
        z_in = 1'b1;
        step();
        z_in = 1'b0;
        checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL brz_wrap_back: got %h expected %h", imem_addr, 16'hFFFF); end
        // BRN offset 0 at 0xFFFF -> 0x0000
        fetch(16'hC200, 1);
        n_in = 1'b1;
        step();
        n_in = 1'b0;
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL brn_wrap: got %h expected %h", imem_addr, 16'h0000); end
    endtask

    task automatic test_halt();
        fetch(16'h7E00, 0);
        checks++; if ({RW, mem_we, halted} !== 3'b000) begin errors++; $display("FAIL hlt_exec: got %b expected %b", {RW, mem_we, halted}, 3'b000); end
        step();
        imem_valid = 1'b1;
        imem_data  = 16'h0491;
        step();
        step();
        imem_valid = 1'b0;
        checks++; if ({halted, imem_req, RW} !== 3'b100) begin errors++; $display("FAIL hlt_state: got %b expected %b", {halted, imem_req, RW}, 3'b100); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL hlt_pc: got %h expected %h", imem_addr, 16'h0000); end
    endtask

    task automatic test_reset_mid_exec();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({halted, illegal, imem_req} !== 3'b001) begin errors++; $display("FAIL rst_clear: got %b expected %b", {halted, illegal, imem_req}, 3'b001); end
        fetch(16'h0491, 0);
        step();
        fetch(16'h401A, 0);
        checks++; if ({mem_we, imem_addr} !== {1'b1, 16'h0001}) begin errors++; $display("FAIL st_pre_rst: got %h expected %h", {mem_we, imem_addr}, {1'b1, 16'h0001}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mem_we, RW} !== 2'b00) begin errors++; $display("FAIL rst_mem_we: got %b expected %b", {mem_we, RW}, 2'b00); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h expected %h", imem_addr, 16'h0000); end
        @(negedge clk);
        rst_n = 1'b1;
        fetch(16'h8505, 0);
        checks++; if ({MB, RW, DA} !== {2'b11, 3'd4}) begin errors++; $display("FAIL post_rst_exec: got %h expected %h", {MB, RW, DA}, {2'b11, 3'd4}); end
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        z_in       = 1'b0;
        n_in       = 1'b0;
        test_reset();
        test_alu_reg();
        test_alu_imm();
        test_ld_st();
        test_wait_illegal();
        test_branch();
        test_halt();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
